dr_uart_dumper: RTL
===================

// Module: dr_uart_dumper
// PURPOSE
//   Downstream consumer of the OSECPU debug outputs (dr, pc). Detects every change of dr (written by CPDR)
//   and streams it over a TX-only 8N1 UART as ASCII hex terminated by CR LF, so board bring-up can
//   read CPDR results on a serial terminal. Sits beside the OSECPU top in the FPGA wrapper.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
// PORTS
//   clk      in   1   system clock; all logic on posedge
//   reset    in   1   synchronous, active-high reset
//   dr       in   32  OSECPU debug register; reset value 0
//   pc       in   16  OSECPU program counter (used only with DRDUMP_PC_EN)
//   tx       out  1   UART line, idle high
//   busy     out  1   high while a frame is in flight or a snapshot is pending
//   overrun  out  1   sticky: a snapshot was overwritten before transmission
// BEHAVIOUR
//   Reset: tx=1, busy=0, overrun=0, shadow=0, pending_valid=0, FSM=IDLE, all counters 0.
//   Reset mid-frame aborts the frame; tx=1 from the first edge after reset, nothing is resumed.
//   Change detect: each edge compares dr with shadow; if different, shadow<=dr, pending<={dr,pc},
//     pending_valid<=1. dr resetting to 0 therefore produces no frame.
//   Buffering: one in-flight frame register + one pending register. Change while pending_valid=1:
//     pending overwritten with newest value, overrun<=1. Change on the same edge that IDLE/NEXT
//     consumes pending: consumed value moves to frame, new value enters pending, no overrun.
//   FSM: IDLE -> (pending_valid) LOAD frame, clear pending_valid -> START (tx=0, CLKS_PER_BIT cycles)
//     -> DATA (8 bits LSB first, CLKS_PER_BIT each) -> STOP (tx=1, CLKS_PER_BIT) -> NEXT:
//     more chars -> START; else pending_valid -> LOAD; else IDLE.
//   Latency: dr changes before edge N -> pending at N -> LOAD at N+1 -> tx falls at edge N+2.
//   Back-to-back frames: exactly one stop bit between chars and between frames (no extra idle).
//   Character order: 8 hex digits of dr, MSB nibble first, then 0x0D, 0x0A (10 chars).
//   Hex encode: nibble 0..9 -> 0x30+n; 10..15 -> 0x41+(n-10) (uppercase).
//   Bit counter 0..CLKS_PER_BIT-1 wraps to 0 at each bit boundary; char index 0..N-1.
//   busy = (FSM!=IDLE) | pending_valid. overrun cleared only by reset.
// CONFIGURATION
//   `DRDUMP_PC_EN defined: frame = 4 hex digits of pc captured with dr, ':' (0x3A), 8 hex of dr,
//     CR LF (15 chars). pc is sampled on the same edge as the dr change.
//   Not defined: pc ignored, 10-char frame as above; no pc storage synthesized.
// STRUCTURE
//   def.v: state encodings `DRD_IDLE/`DRD_LOAD/`DRD_START/`DRD_DATA/`DRD_STOP/`DRD_NEXT,
//     ASCII constants `ASCII_CR, `ASCII_LF, `ASCII_COLON, frame length `DRD_FRAME_LEN.
//   Sub-module uart_tx_byte (byte in, start strobe, done pulse, tx) holds START/DATA/STOP timing;
//     dr_uart_dumper keeps change detect, pending buffer, hex encode and char sequencing.
// TESTING (CLKS_PER_BIT=4)
//   dr 0 -> 0x0000002A, held: tx falls 2 edges later; decoded "0000002A\r\n"; busy high 400 cycles.
//   dr held at 0 after reset for 1000 cycles -> tx stays 1, busy=0, overrun=0.
//   dr 0x1, then 0x2 mid-frame, then 0x3 before frame 1 ends -> frames "00000001","00000003"; overrun=1.
//   dr 0xDEADBEEF then 0x12345678 during frame 1 -> both frames, 1 stop bit gap, overrun=0.
//   reset asserted during DATA of char 3 -> tx=1 next edge, busy=0; no further output.
//   `DRDUMP_PC_EN, pc=0x00A4, dr=0xFFFFFFFF -> "00A4:FFFFFFFF\r\n", 15 chars, 600 busy cycles.

Source files
------------

// File: rtl/dr_uart_dumper_pkg.sv
// Shared types, ASCII constants and character encoding for the dr_uart_dumper slice.
// Build option: DRDUMP_PC_EN prefixes each frame with the captured pc ("PPPP:").
package dr_uart_dumper_pkg;

    typedef enum logic [1:0] {DRD_IDLE, DRD_LOAD, DRD_SEND} drd_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

`ifdef DRDUMP_PC_EN
    localparam int unsigned DRD_FRAME_LEN = 15;
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] dr;
    } frame_t;
`else
    localparam int unsigned DRD_FRAME_LEN = 10;
    typedef struct packed {
        logic [31:0] dr;
    } frame_t;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Character idx of a frame; hex digits are taken MSB nibble first.
    function automatic logic [7:0] frame_char(input frame_t f, input logic [3:0] idx);
        logic [31:0] d;
        logic [7:0]  c;
`ifdef DRDUMP_PC_EN
        logic [15:0] p;
        p = f.pc << {idx, 2'b00};
        d = f.dr << {idx - 4'd5, 2'b00};
        if (idx < 4'd4)        c = hex_char(p[15:12]);
        else if (idx == 4'd4)  c = ASCII_COLON;
        else if (idx < 4'd13)  c = hex_char(d[31:28]);
        else if (idx == 4'd13) c = ASCII_CR;
        else                   c = ASCII_LF;
`else
        d = f.dr << {idx, 2'b00};
        if (idx < 4'd8)       c = hex_char(d[31:28]);
        else if (idx == 4'd8) c = ASCII_CR;
        else                  c = ASCII_LF;
`endif
        return c;
    endfunction

endpackage

// File: rtl/dr_uart_dumper_if.sv
// Debug-port bundle between the OSECPU wrapper (master) and dr_uart_dumper (slave).
interface dr_uart_dumper_if;
    logic [31:0] dr;
    logic [15:0] pc;
    logic        tx;
    logic        busy;
    logic        overrun;

    modport master (output dr, output pc, input tx, input busy, input overrun);
    modport slave  (input dr, input pc, output tx, output busy, output overrun);
endinterface

// File: rtl/dr_uart_dumper_uart_tx_byte.sv
// 8N1 byte transmitter; a start strobe during the last stop-bit cycle chains the
// next byte with no idle gap, and done marks that last stop-bit cycle.
module uart_tx_byte
    import dr_uart_dumper_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx
);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;

    assign bit_end = (cnt == LAST_CNT);
    assign done    = (state == TX_STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            tx      <= 1'b1;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            cnt <= (state == TX_IDLE || bit_end) ? 16'd0 : cnt + 16'd1;
            case (state)
                TX_IDLE: if (start) begin
                    state <= TX_START;
                    tx    <= 1'b0;
                    shreg <= data;
                end
                TX_START: if (bit_end) begin
                    state   <= TX_DATA;
                    tx      <= shreg[0];
                    bit_idx <= 3'd0;
                end
                TX_DATA: if (bit_end) begin
                    shreg <= shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state <= TX_STOP;
                        tx    <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx      <= shreg[1];
                    end
                end
                TX_STOP: if (bit_end) begin
                    if (start) begin
                        state <= TX_START;
                        tx    <= 1'b0;
                        shreg <= data;
                    end else begin
                        state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dr_uart_dumper.sv
// Watches dr for changes and streams each new value as ASCII hex + CR LF over a TX-only UART.
// Build option: DRDUMP_PC_EN adds the pc captured with dr as a 4-digit prefix and ':'.
module dr_uart_dumper
    import dr_uart_dumper_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input logic             clk,
    input logic             reset,
    dr_uart_dumper_if.slave bus
);
    drd_state_t  state;
    frame_t      frame;
    frame_t      pending;
    frame_t      snap;
    logic [31:0] shadow;
    logic        pending_valid;
    logic        overrun_q;
    logic [3:0]  char_idx;
    logic        change;
    logic        last_char;
    logic        consume;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  tx_data;

    assign change    = (bus.dr != shadow);
    assign last_char = (char_idx == 4'(DRD_FRAME_LEN - 1));
    assign consume   = pending_valid &&
                       ((state == DRD_IDLE) || (state == DRD_SEND && tx_done && last_char));

`ifdef DRDUMP_PC_EN
    always_comb begin
        snap    = '0;
        snap.dr = bus.dr;
        snap.pc = bus.pc;
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.pc;
    always_comb begin
        snap    = '0;
        snap.dr = bus.dr;
    end
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        tx_start = 1'b0;
        tx_data  = frame_char(frame, char_idx);
        case (state)
            DRD_LOAD: tx_start = 1'b1;
            DRD_SEND: if (tx_done) begin
                if (!last_char) begin
                    tx_start = 1'b1;
                    tx_data  = frame_char(frame, char_idx + 4'd1);
                end else if (pending_valid) begin
                    tx_start = 1'b1;
                    tx_data  = frame_char(pending, 4'd0);
                end
            end
            default: ;
        endcase
    end

    // NOTE: frame and pending are plain registers, so they are reset with the control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= DRD_IDLE;
            frame         <= '0;
            pending       <= '0;
            shadow        <= 32'd0;
            pending_valid <= 1'b0;
            overrun_q     <= 1'b0;
            char_idx      <= 4'd0;
        end else begin
            if (change) begin
                shadow  <= bus.dr;
                pending <= snap;
            end
            // A change on the consuming edge refills pending without counting as an overrun.
            pending_valid <= change | (pending_valid & ~consume);
            if (change && pending_valid && !consume) overrun_q <= 1'b1;

            case (state)
                DRD_IDLE: if (pending_valid) begin
                    state    <= DRD_LOAD;
                    frame    <= pending;
                    char_idx <= 4'd0;
                end
                DRD_LOAD: state <= DRD_SEND;
                DRD_SEND: if (tx_done) begin
                    if (!last_char) begin
                        char_idx <= char_idx + 4'd1;
                    end else if (pending_valid) begin
                        frame    <= pending;
                        char_idx <= 4'd0;
                    end else begin
                        state <= DRD_IDLE;
                    end
                end
                default: state <= DRD_IDLE;
            endcase
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (tx_start),
        .data  (tx_data),
        .done  (tx_done),
        .tx    (bus.tx)
    );

    assign bus.busy    = (state != DRD_IDLE) | pending_valid;
    assign bus.overrun = overrun_q;

endmodule
